// File: rtl/feed_progress_overlay.sv
// Feed timer FSM driving a proportional progress bar, plus a 2-stage VGA overlay for the label and bar.
// Define FEED_PAUSE_EN to add a PAUSE state that freezes progress while feed is low.
module feed_progress_overlay #(
    parameter int unsigned NUM_SEGS      = 10,
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned DUR_W         = 8,
    parameter int unsigned LABEL_LEN     = 10,
    parameter logic [8*LABEL_LEN-1:0] LABEL_TEXT = "~hhglqjxyz",
    parameter int unsigned LBL_X0        = 60,
    parameter int unsigned LBL_Y0        = 165,
    parameter int unsigned BAR_X0        = 14,
    parameter int unsigned BAR_Y0        = 10,
    parameter int unsigned BAR_PITCH     = 64,
    parameter int unsigned BAR_W         = 50,
    parameter int unsigned BAR_H         = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             feed,
    input  logic [DUR_W-1:0] duration,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    output logic             busy,
    output logic             done_pulse,
    output logic [4:0]       filled_segs,
    output logic             label_hit,
    output logic             bar_hit,
    output logic [7:0]       char_code,
    output logic [18:0]      sprite_addr
);
    localparam int unsigned ACC_W  = DUR_W + 5;
    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned CELL_W = 50;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DX_W   = 10;
    localparam int unsigned DY_W   = 9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_PAUSE} state_t;

    state_t               state_q, state_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [ACC_W-1:0]     secs_q, secs_d, acc_q, acc_d;
    logic [4:0]           filled_q, filled_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic [LABEL_LEN-1:0] lvec_q, lvec_d;
    logic [NUM_SEGS-1:0]  bvec_q, bvec_d;
    logic [IDX_W-1:0]     idx_q, idx_d, lidx, bidx;
    logic [DX_W-1:0]      dx_q, dx_d;
    logic [DY_W-1:0]      dy_q, dy_d;

    logic                 label_hit_q, label_hit_d, bar_hit_q, bar_hit_d;
    logic [7:0]           char_q, char_d;
    logic [18:0]          addr_q, addr_d;

    logic [ACC_W-1:0]     dur_ext;
    logic                 wrap, norm;
    logic [31:0]          px, py;

    assign dur_ext = ACC_W'(dur_q);
    assign px      = 32'(x);
    assign py      = 32'(y);

    // Feed timer: ticks -> seconds, each second adds NUM_SEGS to acc, normalised by dur one step per cycle
    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        tick_d   = tick_q;
        secs_d   = secs_q;
        acc_d    = acc_q;
        filled_d = filled_q;
        done_d   = 1'b0;
        wrap     = 1'b0;
        norm     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (feed) begin
                    dur_d    = duration;
                    tick_d   = '0;
                    secs_d   = '0;
                    acc_d    = '0;
                    filled_d = '0;
                    if (duration == '0) begin
                        state_d  = S_DONE;
                        filled_d = 5'(NUM_SEGS);
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!feed) begin
`ifdef FEED_PAUSE_EN
                    state_d = S_PAUSE;
`else
                    state_d  = S_IDLE;
                    tick_d   = '0;
                    secs_d   = '0;
                    acc_d    = '0;
                    filled_d = '0;
`endif
                end else if (secs_q == dur_ext && acc_q < dur_ext) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (secs_q != dur_ext) begin
                        if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
                            tick_d = '0;
                            secs_d = secs_q + ACC_W'(1);
                            wrap   = 1'b1;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                    norm  = (acc_q >= dur_ext);
                    acc_d = acc_q + (wrap ? ACC_W'(NUM_SEGS) : '0) - (norm ? dur_ext : '0);
                    if (norm && filled_q < 5'(NUM_SEGS)) begin
                        filled_d = filled_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (!feed) begin
                    state_d  = S_IDLE;
                    filled_d = '0;
                end
            end
`ifdef FEED_PAUSE_EN
            S_PAUSE: begin
                if (feed) begin
                    state_d = S_RUN;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    // Pixel stage 1: cell hit vectors, winning cell index and offsets within that cell
    always_comb begin
        lvec_d = '0;
        bvec_d = '0;
        lidx   = '0;
        bidx   = '0;
        for (int k = 0; k < int'(LABEL_LEN); k++) begin
            lvec_d[k] = (px >= 32'(LBL_X0 + CELL_W * k)) && (px < 32'(LBL_X0 + CELL_W * (k + 1))) &&
                        (py >= 32'(LBL_Y0)) && (py < 32'(LBL_Y0 + CELL_W));
        end
        for (int k = 0; k < int'(NUM_SEGS); k++) begin
            bvec_d[k] = (px >= 32'(BAR_X0 + BAR_PITCH * k)) && (px < 32'(BAR_X0 + BAR_PITCH * k + BAR_W)) &&
                        (py >= 32'(BAR_Y0)) && (py < 32'(BAR_Y0 + BAR_H)) && (5'(k) < filled_q);
        end
        for (int k = int'(LABEL_LEN) - 1; k >= 0; k--) begin
            if (lvec_d[k]) lidx = IDX_W'(k);
        end
        for (int k = int'(NUM_SEGS) - 1; k >= 0; k--) begin
            if (bvec_d[k]) bidx = IDX_W'(k);
        end
        if (|lvec_d) begin
            idx_d = lidx;
            dx_d  = DX_W'(px - (32'(LBL_X0) + 32'(CELL_W) * 32'(lidx)));
            dy_d  = DY_W'(py - 32'(LBL_Y0));
        end else begin
            idx_d = bidx;
            dx_d  = DX_W'(px - (32'(BAR_X0) + 32'(BAR_PITCH) * 32'(bidx)));
            dy_d  = DY_W'(py - 32'(BAR_Y0));
        end
    end

    // Pixel stage 2: glyph lookup and sprite address, label wins over bar
    always_comb begin
        label_hit_d = |lvec_q;
        bar_hit_d   = !label_hit_d && (|bvec_q);
        char_d      = '0;
        addr_d      = '0;
        for (int k = 0; k < int'(LABEL_LEN); k++) begin
            if (label_hit_d && idx_q == IDX_W'(k)) begin
                char_d = LABEL_TEXT[8*(int'(LABEL_LEN) - 1 - k) +: 8];
            end
        end
        if (label_hit_d) begin
            addr_d = (19'(char_d) - 19'd33) * 19'd2500 + 19'(dx_q) + 19'(dy_q) * 19'(CELL_W);
        end else if (bar_hit_d) begin
            addr_d = 19'(dx_q) + 19'(dy_q) * 19'(BAR_W);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            dur_q       <= '0;
            tick_q      <= '0;
            secs_q      <= '0;
            acc_q       <= '0;
            filled_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lvec_q      <= '0;
            bvec_q      <= '0;
            idx_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            label_hit_q <= 1'b0;
            bar_hit_q   <= 1'b0;
            char_q      <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            dur_q       <= dur_d;
            tick_q      <= tick_d;
            secs_q      <= secs_d;
            acc_q       <= acc_d;
            filled_q    <= filled_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lvec_q      <= lvec_d;
            bvec_q      <= bvec_d;
            idx_q       <= idx_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            label_hit_q <= label_hit_d;
            bar_hit_q   <= bar_hit_d;
            char_q      <= char_d;
            addr_q      <= addr_d;
        end
    end

    assign busy        = busy_q;
    assign done_pulse  = done_q;
    assign filled_segs = filled_q;
    assign label_hit   = label_hit_q;
    assign bar_hit     = bar_hit_q;
    assign char_code   = char_q;
    assign sprite_addr = addr_q;

endmodule

// File: tb/tb_feed_progress_overlay.sv
// Directed bench for feed_progress_overlay with a 4-cycle second; follows FEED_PAUSE_EN if defined.
module tb_feed_progress_overlay;
    logic        clk = 1'b0;
    logic        reset;
    logic        feed;
    logic [7:0]  duration;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        busy, done_pulse, label_hit, bar_hit;
    logic [4:0]  filled_segs;
    logic [7:0]  char_code;
    logic [18:0] sprite_addr;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    feed_progress_overlay #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .feed(feed), .duration(duration), .x(x), .y(y),
        .busy(busy), .done_pulse(done_pulse), .filled_segs(filled_segs),
        .label_hit(label_hit), .bar_hit(bar_hit), .char_code(char_code), .sprite_addr(sprite_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_pulse === 1'b1) done_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; feed = 1'b0; duration = 8'd0; x = 10'd0; y = 9'd0;
        #23;
        check("rst_busy", 32'(busy), 0);
        check("rst_filled", 32'(filled_segs), 0);
        check("rst_done", 32'(done_pulse), 0);
        check("rst_addr", 32'(sprite_addr), 0);
        reset = 1'b1;
        cyc(1);

        // label cell 1 ('h') at dx=5, dy=5
        x = 10'd115; y = 9'd170;
        cyc(2);
        check("lbl_hit", 32'(label_hit), 1);
        check("lbl_char", 32'(char_code), 104);
        check("lbl_addr", 32'(sprite_addr), 177755);
        check("lbl_bar", 32'(bar_hit), 0);
        x = 10'd109;
        cyc(2);
        check("lbl_c0_char", 32'(char_code), 126);
        check("lbl_c0_addr", 32'(sprite_addr), 232799);
        x = 10'd560;
        cyc(2);
        check("lbl_right_edge", 32'(label_hit), 0);
        check("lbl_right_char", 32'(char_code), 0);
        x = 10'd115; y = 9'd215;
        cyc(2);
        check("lbl_bottom_edge", 32'(label_hit), 0);
        x = 10'd0; y = 9'd0;

        // duration 4, feed held
        duration = 8'd4; feed = 1'b1;
        cyc(1);
        check("t1_busy", 32'(busy), 1);
        check("t1_f0", 32'(filled_segs), 0);
        duration = 8'd200;
        cyc(7);
        check("t1_f_s1", 32'(filled_segs), 2);
        cyc(4);
        check("t1_f_s2", 32'(filled_segs), 5);
        cyc(4);
        check("t1_f_s3", 32'(filled_segs), 7);
        cyc(4);
        check("t1_f_s4", 32'(filled_segs), 10);
        check("t1_busy_pre", 32'(busy), 1);
        check("t1_nodone_pre", 32'(done_pulse), 0);
        cyc(1);
        check("t1_done", 32'(done_pulse), 1);
        check("t1_busy_done", 32'(busy), 0);
        cyc(1);
        check("t1_done_once", 32'(done_pulse), 0);
        check("t1_done_cnt", 32'(done_cnt), 1);
        check("t1_hold", 32'(filled_segs), 10);
        feed = 1'b0;
        cyc(1);
        check("t1_idle_filled", 32'(filled_segs), 0);

        // zero duration
        duration = 8'd0; feed = 1'b1;
        cyc(1);
        check("t2_filled", 32'(filled_segs), 10);
        check("t2_done", 32'(done_pulse), 1);
        check("t2_busy", 32'(busy), 0);
        cyc(1);
        check("t2_done_cnt", 32'(done_cnt), 2);
        feed = 1'b0;
        cyc(1);
        check("t2_idle", 32'(filled_segs), 0);

        // duration 30: filled reaches 3 after 9 s, bar pixel checks
        duration = 8'd30; feed = 1'b1;
        cyc(1);
        cyc(38);
        check("t4_filled3", 32'(filled_segs), 3);
        x = 10'd142; y = 9'd10;
        cyc(2);
        check("t4_seg2_hit", 32'(bar_hit), 1);
        check("t4_seg2_addr", 32'(sprite_addr), 0);
        x = 10'd206;
        cyc(2);
        check("t4_seg3_unlit", 32'(bar_hit), 0);
        x = 10'd64;
        cyc(2);
        check("t4_seg0_edge", 32'(bar_hit), 0);
        x = 10'd150; y = 9'd20;
        cyc(2);
        check("t4_seg2_inner", 32'(sprite_addr), 508);
        cyc(4);
        check("t6_filled4", 32'(filled_segs), 4);

        // async reset mid-run
        #2 reset = 1'b0;
        #1;
        check("t6_rst_filled", 32'(filled_segs), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_bar", 32'(bar_hit), 0);
        #3 reset = 1'b1;
        cyc(1);
        check("t6_restart_busy", 32'(busy), 1);
        check("t6_restart_filled", 32'(filled_segs), 0);
        cyc(5);
        check("t6_restart_f", 32'(filled_segs), 0);
        feed = 1'b0;
        cyc(1);
        check("t6_abort_busy", 32'(busy), 0);
        x = 10'd0; y = 9'd0;

        // duration 6, feed dropped after second 3
        duration = 8'd6; feed = 1'b1;
        cyc(1);
        cyc(14);
        check("t5_f_s3", 32'(filled_segs), 5);
        feed = 1'b0;
        cyc(1);
`ifdef FEED_PAUSE_EN
        check("t5_pause_filled", 32'(filled_segs), 5);
        check("t5_pause_busy", 32'(busy), 1);
        cyc(6);
        check("t5_pause_frozen", 32'(filled_segs), 5);
        feed = 1'b1;
        cyc(30);
        check("t5_resume_filled", 32'(filled_segs), 10);
        check("t5_resume_busy", 32'(busy), 0);
        check("t5_resume_done", 32'(done_cnt), 3);
        feed = 1'b0;
        cyc(1);
`else
        check("t5_abort_filled", 32'(filled_segs), 0);
        check("t5_abort_busy", 32'(busy), 0);
        cyc(30);
        check("t5_abort_nodone", 32'(done_cnt), 2);
        check("t5_abort_stays", 32'(filled_segs), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
